// File: rtl/iic_cfg_seq.sv
// I2C configuration sequencer: divides clk_8m into clk_i and walks an external register
// table through iic_drive, retrying failed writes. Define IIC_VERIFY_EN to add write read-back.
module iic_cfg_seq #(
  parameter int          CLK_DIV     = 10,
  parameter int          NUM_ENTRIES = 16,
  parameter int          REG_AW      = 16,
  parameter int          MAX_RETRY   = 3,
  parameter logic [7:0]  DEV_ADDR    = 8'h78,
  parameter int          BUSY_TO     = 4095
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic        clk_i,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_reg,
  input  logic [7:0]  tbl_data,
  output logic        start_en,
  output logic        wr_rd_flag,
  output logic [7:0]  i2c_device_addr,
  output logic [15:0] register,
  output logic [7:0]  data_byte,
  input  logic        busy,
  input  logic        err,
  input  logic [7:0]  rd_data,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_fail,
  output logic [7:0]  fail_index,
  output logic [7:0]  retry_total
);

`ifdef IIC_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  localparam int            TW        = $clog2(BUSY_TO + 1);
  localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(BUSY_TO - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [8:0]    IDX_END   = 9'(NUM_ENTRIES);

  typedef enum logic [3:0] {
    IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, CHECK, NEXT, DONE, FAIL
  } state_t;

  state_t        state, state_n;
  logic [7:0]    div_cnt;
  logic          busy_s1, busy_s2, err_s1, err_s2;
  logic          start_s1, start_s2, start_s3, start_edge;
  logic [8:0]    idx, idx_n;
  logic [3:0]    retry_cnt, retry_n;
  logic [7:0]    total_n, fidx_n, data_n, dev_n;
  logic [TW-1:0] to_cnt, to_n;
  logic          att_err, att_err_n, att_fail, rd_phase, rd_phase_n;
  logic          start_n, wr_n, cbusy_n, done_n, fail_n;
  logic [15:0]   reg_n;

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
      clk_i   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 8'd0;
      clk_i   <= ~clk_i;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // busy/err come from the clk_i domain; cfg_start is asynchronous to everything
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      {busy_s2, busy_s1}            <= 2'b00;
      {err_s2, err_s1}              <= 2'b00;
      {start_s3, start_s2, start_s1} <= 3'b000;
    end else begin
      {busy_s2, busy_s1}            <= {busy_s1, busy};
      {err_s2, err_s1}              <= {err_s1, err};
      {start_s3, start_s2, start_s1} <= {start_s2, start_s1, cfg_start};
    end
  end

  assign start_edge = start_s2 & ~start_s3;
  assign tbl_addr   = idx[7:0];

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= 9'd0;
      retry_cnt       <= 4'd0;
      retry_total     <= 8'd0;
      to_cnt          <= '0;
      att_err         <= 1'b0;
      rd_phase        <= 1'b0;
      start_en        <= 1'b0;
      wr_rd_flag      <= 1'b0;
      register        <= 16'd0;
      data_byte       <= 8'd0;
      i2c_device_addr <= 8'd0;
      cfg_busy        <= 1'b0;
      cfg_done        <= 1'b0;
      cfg_fail        <= 1'b0;
      fail_index      <= 8'd0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      retry_cnt       <= retry_n;
      retry_total     <= total_n;
      to_cnt          <= to_n;
      att_err         <= att_err_n;
      rd_phase        <= rd_phase_n;
      start_en        <= start_n;
      wr_rd_flag      <= wr_n;
      register        <= reg_n;
      data_byte       <= data_n;
      i2c_device_addr <= dev_n;
      cfg_busy        <= cbusy_n;
      cfg_done        <= done_n;
      cfg_fail        <= fail_n;
      fail_index      <= fidx_n;
    end
  end

  // A read-back attempt fails on err or on data that differs from what was written
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    retry_n    = retry_cnt;
    total_n    = retry_total;
    to_n       = to_cnt;
    att_err_n  = att_err;
    rd_phase_n = rd_phase;
    start_n    = start_en;
    wr_n       = wr_rd_flag;
    reg_n      = register;
    data_n     = data_byte;
    dev_n      = i2c_device_addr;
    cbusy_n    = cfg_busy;
    done_n     = cfg_done;
    fail_n     = cfg_fail;
    fidx_n     = fail_index;
    att_fail   = att_err | (VERIFY_EN & rd_phase & (rd_data != data_byte));

    case (state)
      IDLE: begin
        if (start_edge) begin
          done_n  = 1'b0;
          fail_n  = 1'b0;
          fidx_n  = 8'd0;
          total_n = 8'd0;
          idx_n   = 9'd0;
          retry_n = 4'd0;
          cbusy_n = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        reg_n      = (REG_AW == 8) ? {8'h00, tbl_reg[7:0]} : tbl_reg;
        data_n     = tbl_data;
        dev_n      = DEV_ADDR;
        wr_n       = 1'b0;
        rd_phase_n = 1'b0;
        state_n    = ((idx == IDX_END) || (tbl_reg == 16'hFFFF)) ? DONE : ISSUE;
      end
      ISSUE: begin
        start_n   = 1'b1;
        att_err_n = 1'b0;
        to_n      = '0;
        state_n   = WAIT_HI;
      end
      WAIT_HI: begin
        if (err_s2) att_err_n = 1'b1;
        if (busy_s2) begin
          start_n = 1'b0;
          state_n = WAIT_LO;
        end else if (to_cnt == TO_LAST) begin
          start_n   = 1'b0;
          att_err_n = 1'b1;
          state_n   = CHECK;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      WAIT_LO: begin
        if (err_s2) att_err_n = 1'b1;
        if (!busy_s2) state_n = CHECK;
      end
      CHECK: begin
        if (!att_fail) begin
          if (VERIFY_EN && !rd_phase) begin
            rd_phase_n = 1'b1;
            wr_n       = 1'b1;
            state_n    = ISSUE;
          end else begin
            state_n = NEXT;
          end
        end else if (retry_cnt < RETRY_MAX) begin
          retry_n    = retry_cnt + 4'd1;
          total_n    = (retry_total == 8'hFF) ? 8'hFF : retry_total + 8'd1;
          rd_phase_n = 1'b0;
          wr_n       = 1'b0;
          state_n    = ISSUE;
        end else begin
          fidx_n  = idx[7:0];
          state_n = FAIL;
        end
      end
      NEXT: begin
        idx_n   = idx + 9'd1;
        retry_n = 4'd0;
        state_n = LOAD;
      end
      DONE: begin
        done_n  = 1'b1;
        cbusy_n = 1'b0;
        state_n = IDLE;
      end
      FAIL: begin
        fail_n  = 1'b1;
        cbusy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Self-checking bench for iic_cfg_seq: a behavioural iic_drive model pops expected
// transactions from a scoreboard queue as the DUT issues them.
module tb_iic_cfg_seq;
  localparam int BUSY_TO   = 4095;
  localparam int MAX_RETRY = 3;

  typedef struct packed {
    logic [15:0] rg;
    logic [7:0]  dt;
    logic        rw;
  } xact_t;

  logic        clk_8m = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        busy = 1'b0;
  logic        err = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        clk_i, start_en, wr_rd_flag, cfg_busy, cfg_done, cfg_fail;
  logic [7:0]  tbl_addr, tbl_data, i2c_device_addr, data_byte, fail_index, retry_total;
  logic [15:0] tbl_reg, register;

  logic [15:0] tbl_reg_mem [256];
  logic [7:0]  tbl_data_mem [256];
  int          err_first [256];
  int          att_cnt [256];
  bit          mute = 1'b0;
  bit          rd_fault = 1'b0;
  xact_t       exp_q [$];
  int          checks = 0;
  int          failures = 0;

  assign tbl_reg  = tbl_reg_mem[tbl_addr];
  assign tbl_data = tbl_data_mem[tbl_addr];

  always #5 clk_8m = ~clk_8m;

  iic_cfg_seq #(.MAX_RETRY(MAX_RETRY), .BUSY_TO(BUSY_TO)) dut (
    .clk_8m(clk_8m), .rst_n(rst_n), .cfg_start(cfg_start), .clk_i(clk_i),
    .tbl_addr(tbl_addr), .tbl_reg(tbl_reg), .tbl_data(tbl_data),
    .start_en(start_en), .wr_rd_flag(wr_rd_flag), .i2c_device_addr(i2c_device_addr),
    .register(register), .data_byte(data_byte), .busy(busy), .err(err),
    .rd_data(rd_data), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail),
    .fail_index(fail_index), .retry_total(retry_total)
  );

  // iic_drive stand-in: each start_en request is checked against the scoreboard head
  initial begin : drive_model
    xact_t got, want;
    logic  bad;
    forever begin
      @(negedge clk_8m);
      if (rst_n === 1'b1 && start_en === 1'b1) begin
        got.rg = register;
        got.dt = data_byte;
        got.rw = wr_rd_flag;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_xact got reg=%h data=%h rw=%b required no transaction",
                   got.rg, got.dt, got.rw);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("[TB] FAIL xact got reg=%h data=%h rw=%b required reg=%h data=%h rw=%b",
                     got.rg, got.dt, got.rw, want.rg, want.dt, want.rw);
          end
        end
        checks++;
        if (i2c_device_addr !== 8'h78) begin
          failures++;
          $display("[TB] FAIL dev_addr got %h required 78", i2c_device_addr);
        end
        if (mute) begin
          for (int k = 0; k < BUSY_TO + 50 && start_en === 1'b1; k++) @(negedge clk_8m);
        end else begin
          bad = 1'b0;
          if (wr_rd_flag === 1'b0) begin
            bad = (att_cnt[tbl_addr] < err_first[tbl_addr]);
            att_cnt[tbl_addr]++;
          end else begin
            rd_data = rd_fault ? 8'h00 : data_byte;
          end
          repeat (3) @(negedge clk_8m);
          busy = 1'b1;
          err  = bad;
          for (int k = 0; k < 20 && start_en === 1'b1; k++) @(negedge clk_8m);
          repeat (8) @(negedge clk_8m);
          busy = 1'b0;
          err  = 1'b0;
        end
      end
    end
  end

  task automatic clear_env();
    for (int i = 0; i < 256; i++) begin
      tbl_reg_mem[i]  = 16'hFFFF;
      tbl_data_mem[i] = 8'h00;
      err_first[i]    = 0;
      att_cnt[i]      = 0;
    end
    mute     = 1'b0;
    rd_fault = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_four();
    tbl_reg_mem[0] = 16'h3008; tbl_data_mem[0] = 8'h82;
    tbl_reg_mem[1] = 16'h3103; tbl_data_mem[1] = 8'h03;
    tbl_reg_mem[2] = 16'h3017; tbl_data_mem[2] = 8'h10;
    tbl_reg_mem[3] = 16'h3018; tbl_data_mem[3] = 8'hFF;
  endtask

  // One issued write; with read-back enabled a write that succeeds is followed by its read
  task automatic expect_attempt(input int idx, input bit ok);
    xact_t x;
    x.rg = tbl_reg_mem[idx];
    x.dt = tbl_data_mem[idx];
    x.rw = 1'b0;
    exp_q.push_back(x);
`ifdef IIC_VERIFY_EN
    if (ok) begin
      x.rw = 1'b1;
      exp_q.push_back(x);
    end
`else
    if (ok) x.rw = 1'b0;
`endif
  endtask

  task automatic run_seq(input int budget, input int repulse_at, output int cycles);
    int n;
    cfg_start = 1'b1;
    n = 0;
    while (cfg_busy !== 1'b1 && n < 40) begin @(negedge clk_8m); n++; end
    cfg_start = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_ack cfg_busy got %b required 1", cfg_busy);
    end
    n = 0;
    while (cfg_busy === 1'b1 && n < budget) begin
      @(negedge clk_8m);
      n++;
      if (repulse_at > 0 && n == repulse_at) cfg_start = 1'b1;
      if (repulse_at > 0 && n == repulse_at + 6) cfg_start = 1'b0;
    end
    cycles = n;
    cfg_start = 1'b0;
    checks++;
    if (cfg_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL run_bound cfg_busy got %b required 0 within %0d cycles", cfg_busy, budget);
    end
    repeat (30) @(negedge clk_8m);
  endtask

  task automatic test_reset();
    int first, second;
    logic prev;
    #22;
    checks++;
    if ({clk_i, start_en, wr_rd_flag, cfg_busy, cfg_done, cfg_fail} !== 6'b0 ||
        {tbl_addr, i2c_device_addr, register, data_byte, fail_index, retry_total} !== 64'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got nonzero output(s) required all 0");
    end
    @(negedge clk_8m);
    rst_n = 1'b1;
    first = 0; second = 0; prev = clk_i;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_8m);
      #1;
      if (clk_i === 1'b1 && prev === 1'b0) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      prev = clk_i;
    end
    checks++;
    if (first != 10) begin
      failures++;
      $display("[TB] FAIL clk_i_first_rise got cycle %0d required 10", first);
    end
    checks++;
    if (second - first != 20) begin
      failures++;
      $display("[TB] FAIL clk_i_period got %0d required 20", second - first);
    end
  endtask

  task automatic check_end(input string tag, input bit done, input bit fail,
                           input logic [7:0] fidx, input logic [7:0] tot);
    checks++;
    if (cfg_done !== done || cfg_fail !== fail) begin
      failures++;
      $display("[TB] FAIL %s_status got done=%b fail=%b required done=%b fail=%b",
               tag, cfg_done, cfg_fail, done, fail);
    end
    checks++;
    if (fail_index !== fidx || retry_total !== tot) begin
      failures++;
      $display("[TB] FAIL %s_counts got fail_index=%0d retry_total=%0d required %0d %0d",
               tag, fail_index, retry_total, fidx, tot);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_pending got %0d outstanding transactions required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_nominal();
    int cyc;
    clear_env();
    load_four();
    for (int i = 0; i < 4; i++) expect_attempt(i, 1'b1);
    run_seq(3000, 0, cyc);
    check_end("nominal", 1'b1, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_retry_recovery();
    int cyc;
    clear_env();
    load_four();
    err_first[2] = 2;
    expect_attempt(0, 1'b1);
    expect_attempt(1, 1'b1);
    expect_attempt(2, 1'b0);
    expect_attempt(2, 1'b0);
    expect_attempt(2, 1'b1);
    expect_attempt(3, 1'b1);
    run_seq(4000, 0, cyc);
    check_end("retry_recovery", 1'b1, 1'b0, 8'd0, 8'd2);
  endtask

  task automatic test_retry_exhaustion();
    int cyc;
    clear_env();
    load_four();
    err_first[1] = 99;
    expect_attempt(0, 1'b1);
    for (int a = 0; a <= MAX_RETRY; a++) expect_attempt(1, 1'b0);
    run_seq(4000, 0, cyc);
    check_end("retry_exhaustion", 1'b0, 1'b1, 8'd1, 8'd3);
  endtask

  task automatic test_start_ignored();
    int cyc;
    clear_env();
    load_four();
    for (int i = 0; i < 4; i++) expect_attempt(i, 1'b1);
    run_seq(3000, 40, cyc);
    repeat (40) @(negedge clk_8m);
    checks++;
    if (cfg_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_ignored_rerun cfg_busy got %b required 0", cfg_busy);
    end
    check_end("start_ignored", 1'b1, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_timeout();
    int cyc;
    clear_env();
    load_four();
    mute = 1'b1;
    for (int a = 0; a <= MAX_RETRY; a++) expect_attempt(0, 1'b0);
    run_seq(20000, 0, cyc);
    check_end("timeout", 1'b0, 1'b1, 8'd0, 8'd3);
    checks++;
    if (cyc < (MAX_RETRY + 1) * BUSY_TO || cyc > (MAX_RETRY + 1) * BUSY_TO + 64) begin
      failures++;
      $display("[TB] FAIL timeout_duration got %0d cycles required %0d..%0d",
               cyc, (MAX_RETRY + 1) * BUSY_TO, (MAX_RETRY + 1) * BUSY_TO + 64);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    clear_env();
    load_four();
    expect_attempt(0, 1'b0);
    cfg_start = 1'b1;
    n = 0;
    while (!(busy === 1'b1 && start_en === 1'b0 && cfg_busy === 1'b1) && n < 200) begin
      @(negedge clk_8m);
      n++;
    end
    cfg_start = 1'b0;
    checks++;
    if (n >= 200) begin
      failures++;
      $display("[TB] FAIL abort_reach_wait_lo got no handshake within %0d cycles required one", n);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_i, start_en, cfg_busy, cfg_done, cfg_fail} !== 5'b0 ||
        {tbl_addr, register, data_byte, i2c_device_addr} !== 40'b0) begin
      failures++;
      $display("[TB] FAIL abort_outputs got start_en=%b cfg_busy=%b reg=%h data=%h required all 0",
               start_en, cfg_busy, register, data_byte);
    end
    @(negedge clk_8m);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_8m);
    checks++;
    if (start_en !== 1'b0 || cfg_busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL abort_idle got start_en=%b cfg_busy=%b pending=%0d required 0 0 0",
               start_en, cfg_busy, exp_q.size());
    end
  endtask

`ifdef IIC_VERIFY_EN
  task automatic test_verify();
    int cyc;
    clear_env();
    tbl_reg_mem[0]  = 16'h3100;
    tbl_data_mem[0] = 8'h5A;
    rd_fault = 1'b1;
    for (int a = 0; a <= MAX_RETRY; a++) expect_attempt(0, 1'b1);
    run_seq(4000, 0, cyc);
    check_end("verify", 1'b0, 1'b1, 8'd0, 8'd3);
  endtask
`endif

  initial begin
    clear_env();
    test_reset();
    test_nominal();
    test_retry_recovery();
    test_retry_exhaustion();
    test_start_ignored();
    test_timeout();
    test_reset_abort();
`ifdef IIC_VERIFY_EN
    test_verify();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
